// File: rtl/hazard_tag_pipe.sv
// Tag-tracking shadow of the D/E/M/W pipeline registers that feeds hazard detection and forwarding.
// It also keeps saturating counters for stall cycles, inserted bubbles and retired instructions.
module hazard_tag_pipe #(
    parameter int REGW = 4,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ValidF,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    input  logic            RegWriteD,
    input  logic            ResultSrcD,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            FlushE,
    input  logic            ClrCnt,
    output logic            ValidD,
    output logic [REGW-1:0] Rs1E,
    output logic [REGW-1:0] Rs2E,
    output logic [REGW-1:0] RdE,
    output logic            ResultSrcE,
    output logic [REGW-1:0] RdM,
    output logic            RegWriteM,
    output logic [REGW-1:0] RdW,
    output logic            RegWriteW,
    output logic            ValidW,
    output logic [CNTW-1:0] StallCnt,
    output logic [CNTW-1:0] BubbleCnt,
    output logic [CNTW-1:0] RetireCnt
);

    logic reg_write_e;
    logic valid_e;
    logic valid_m;

    // Clear wins over increment; the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNTW-1:0] cnt_next(input logic clr, input logic inc,
                                                 input logic [CNTW-1:0] cur);
        if (clr) return '0;
        if (inc && (cur != {CNTW{1'b1}})) return cur + 1'b1;
        return cur;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            ValidD      <= 1'b0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            ResultSrcE  <= 1'b0;
            reg_write_e <= 1'b0;
            valid_e     <= 1'b0;
            RdM         <= '0;
            RegWriteM   <= 1'b0;
            valid_m     <= 1'b0;
            RdW         <= '0;
            RegWriteW   <= 1'b0;
            ValidW      <= 1'b0;
            StallCnt    <= '0;
            BubbleCnt   <= '0;
            RetireCnt   <= '0;
        end else begin
            // A taken branch squashes D even while a load-use stall is pending.
            if (FlushD) begin
                ValidD <= 1'b0;
            end else if (!StallD) begin
                ValidD <= ValidF;
            end

            // Tags of an invalid D slot are forced to zero so a bubble never matches a live register.
            if (FlushE || !ValidD) begin
                Rs1E        <= '0;
                Rs2E        <= '0;
                RdE         <= '0;
                ResultSrcE  <= 1'b0;
                reg_write_e <= 1'b0;
                valid_e     <= 1'b0;
            end else begin
                Rs1E        <= Rs1D;
                Rs2E        <= Rs2D;
                RdE         <= RdD;
                ResultSrcE  <= ResultSrcD;
                reg_write_e <= RegWriteD;
                valid_e     <= 1'b1;
            end

            RdM       <= RdE;
            RegWriteM <= reg_write_e;
            valid_m   <= valid_e;

            RdW       <= RdM;
            RegWriteW <= RegWriteM;
            ValidW    <= valid_m;

            StallCnt  <= cnt_next(ClrCnt, StallD & ~FlushD, StallCnt);
            BubbleCnt <= cnt_next(ClrCnt, FlushE, BubbleCnt);
            RetireCnt <= cnt_next(ClrCnt, ValidW, RetireCnt);
        end
    end

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Directed bench for hazard_tag_pipe with 2-bit counters so saturation is reachable quickly.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_hazard_tag_pipe;

    localparam int REGW = 4;
    localparam int CNTW = 2;

    logic            clk;
    logic            reset;
    logic            ValidF;
    logic [REGW-1:0] Rs1D, Rs2D, RdD;
    logic            RegWriteD, ResultSrcD;
    logic            StallD, FlushD, FlushE, ClrCnt;
    logic            ValidD;
    logic [REGW-1:0] Rs1E, Rs2E, RdE;
    logic            ResultSrcE;
    logic [REGW-1:0] RdM;
    logic            RegWriteM;
    logic [REGW-1:0] RdW;
    logic            RegWriteW;
    logic            ValidW;
    logic [CNTW-1:0] StallCnt, BubbleCnt, RetireCnt;

    int n_checks;
    int n_fail;

    hazard_tag_pipe #(.REGW(REGW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ValidF     (ValidF),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RdD        (RdD),
        .RegWriteD  (RegWriteD),
        .ResultSrcD (ResultSrcD),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .ClrCnt     (ClrCnt),
        .ValidD     (ValidD),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .ResultSrcE (ResultSrcE),
        .RdM        (RdM),
        .RegWriteM  (RegWriteM),
        .RdW        (RdW),
        .RegWriteW  (RegWriteW),
        .ValidW     (ValidW),
        .StallCnt   (StallCnt),
        .BubbleCnt  (BubbleCnt),
        .RetireCnt  (RetireCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [REGW-1:0] rs1, input logic [REGW-1:0] rs2,
                         input logic [REGW-1:0] rd, input logic rw, input logic ld);
        Rs1D       = rs1;
        Rs2D       = rs2;
        RdD        = rd;
        RegWriteD  = rw;
        ResultSrcD = ld;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid_d"}, ValidD, 0);
        check({tag, "_rd_e"}, RdE, 0);
        check({tag, "_rs1_e"}, Rs1E, 0);
        check({tag, "_rd_m"}, RdM, 0);
        check({tag, "_rw_m"}, RegWriteM, 0);
        check({tag, "_rd_w"}, RdW, 0);
        check({tag, "_valid_w"}, ValidW, 0);
        check({tag, "_stall_cnt"}, StallCnt, 0);
        check({tag, "_bubble_cnt"}, BubbleCnt, 0);
        check({tag, "_retire_cnt"}, RetireCnt, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        ValidF   = 1'b1;
        StallD   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        ClrCnt   = 1'b0;
        set_d(4'd9, 4'd10, 4'd11, 1'b1, 1'b1);

        // Reset held for two edges with a valid instruction presented.
        step();
        step();
        check_all_zero("reset");

        reset = 1'b1;
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        step();
        check("release_valid_d", ValidD, 1);
        check("release_rd_e", RdE, 0);

        // Straight flow: Rd=5 travels E, M, W.
        set_d(4'd1, 4'd2, 4'd5, 1'b1, 1'b0);
        ValidF = 1'b0;
        step();
        check("flow_rd_e", RdE, 5);
        check("flow_rs1_e", Rs1E, 1);
        check("flow_rs2_e", Rs2E, 2);
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        step();
        check("flow_rd_m", RdM, 5);
        check("flow_rw_m", RegWriteM, 1);
        check("flow_rd_e_after", RdE, 0);
        step();
        check("flow_rd_w", RdW, 5);
        check("flow_rw_w", RegWriteW, 1);
        check("flow_valid_w", ValidW, 1);
        check("flow_retire_before", RetireCnt, 0);
        step();
        check("flow_retire_after", RetireCnt, 1);
        check("flow_valid_w_drained", ValidW, 0);

        // Load-use: D holds the load while E takes a bubble, then it re-enters E.
        ValidF = 1'b1;
        step();
        check("lu_valid_d", ValidD, 1);
        set_d(4'd4, 4'd6, 4'd3, 1'b1, 1'b1);
        ValidF = 1'b0;
        StallD = 1'b1;
        FlushE = 1'b1;
        step();
        check("lu_bubble_rd_e", RdE, 0);
        check("lu_bubble_ld_e", ResultSrcE, 0);
        check("lu_valid_d_held", ValidD, 1);
        check("lu_stall_cnt", StallCnt, 1);
        check("lu_bubble_cnt", BubbleCnt, 1);
        StallD = 1'b0;
        FlushE = 1'b0;
        step();
        check("lu_reenter_rd_e", RdE, 3);
        check("lu_reenter_ld_e", ResultSrcE, 1);
        check("lu_reenter_rs1_e", Rs1E, 4);
        check("lu_reenter_rs2_e", Rs2E, 6);
        check("lu_valid_d_next", ValidD, 0);

        // FlushD and StallD together: the flush wins and no stall is counted.
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        ValidF = 1'b1;
        step();
        check("fds_valid_d_pre", ValidD, 1);
        FlushD = 1'b1;
        StallD = 1'b1;
        step();
        check("fds_valid_d", ValidD, 0);
        check("fds_stall_cnt", StallCnt, 1);
        FlushD = 1'b0;
        StallD = 1'b0;

        // Bubble propagation with counters cleared first.
        ValidF = 1'b1;
        ClrCnt = 1'b1;
        step();
        check("clr_stall_cnt", StallCnt, 0);
        check("clr_bubble_cnt", BubbleCnt, 0);
        check("clr_retire_cnt", RetireCnt, 0);
        ClrCnt = 1'b0;
        set_d(4'd1, 4'd2, 4'd7, 1'b1, 1'b0);
        ValidF = 1'b0;
        FlushE = 1'b1;
        step();
        check("bp_rd_e", RdE, 0);
        check("bp_bubble_cnt", BubbleCnt, 1);
        FlushE = 1'b0;
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        step();
        check("bp_rw_m", RegWriteM, 0);
        check("bp_retire_prior", RetireCnt, 1);
        step();
        check("bp_rw_w", RegWriteW, 0);
        check("bp_valid_w", ValidW, 0);
        step();
        check("bp_retire_unchanged", RetireCnt, 1);

        // Saturation of the 2-bit bubble counter (currently 1).
        FlushE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
        end
        check("sat_bubble_cnt", BubbleCnt, 3);
        ClrCnt = 1'b1;
        step();
        check("sat_clr_priority", BubbleCnt, 0);
        ClrCnt = 1'b0;
        step();
        check("sat_count_after_clr", BubbleCnt, 1);

        // Reset asserted in the middle of a stall and flush.
        StallD = 1'b1;
        ValidF = 1'b1;
        set_d(4'd8, 4'd8, 4'd8, 1'b1, 1'b1);
        step();
        check("pre_reset_stall_cnt", StallCnt, 1);
        reset = 1'b0;
        step();
        check_all_zero("mid_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_tag_pipe.md
Name: hazard_tag_pipe

Overview:
- Tag-tracking pipeline on the other side of the hazard interface: it consumes StallD/FlushD/FlushE and produces the Rs1E/Rs2E/RdE/RdM/RdW, RegWriteM/W and ResultSrcE tags that hazard detection and forwarding compare against.
- Carries D-stage valid plus E/M/W register tags in lockstep with the datapath pipeline registers.
- Applies stall and flush semantics so bubbles never carry live write tags.
- Keeps saturating performance counters for stall cycles, inserted bubbles and retired instructions.

Parameters:
REGW, 4, register-index width (Rs1/Rs2/Rd)
CNTW, 16, width of each performance counter

Ports:
clk  input  1  clock
reset  input  1  synchronous active-low reset (0 = reset on rising clk)
ValidF  input  1  fetch stage presents a real instruction
Rs1D  input  REGW  decode-stage source 1 index
Rs2D  input  REGW  decode-stage source 2 index
RdD  input  REGW  decode-stage destination index
RegWriteD  input  1  decode-stage instruction writes Rd
ResultSrcD  input  1  decode-stage instruction is a load
StallD  input  1  hold D register
FlushD  input  1  squash D register
FlushE  input  1  insert bubble into E
ClrCnt  input  1  synchronous clear of all counters
ValidD  output  1  D register holds a real instruction
Rs1E  output  REGW  E-stage source 1
Rs2E  output  REGW  E-stage source 2
RdE  output  REGW  E-stage destination
ResultSrcE  output  1  E-stage instruction is a load
RdM  output  REGW  M-stage destination
RegWriteM  output  1  M-stage write enable
RdW  output  REGW  W-stage destination
RegWriteW  output  1  W-stage write enable
ValidW  output  1  W stage holds a real instruction
StallCnt  output  CNTW  cycles D was stalled
BubbleCnt  output  CNTW  bubbles inserted into E
RetireCnt  output  CNTW  valid instructions leaving W

Behaviour:
- Reset (reset=0 at a rising clk): every register and output is 0. Reset overrides all other inputs, including when asserted mid-stall or mid-flush.
- D valid: if FlushD, ValidD<=0; else if StallD, hold; else ValidD<=ValidF. FlushD has priority over StallD when both are asserted (branch taken while a load stall is pending).
- E stage: if FlushE, load a bubble:
  - Rs1E=Rs2E=RdE=0, ResultSrcE=0.
  - Internal RegWriteE=0 and ValidE=0.
- E stage, otherwise: load Rs1D, Rs2D, RdD, ResultSrcD&ValidD, RegWriteD&ValidD and ValidD.
  - When ValidD=0, all tags load as 0.
- M stage <= E unconditionally every cycle: RdM, RegWriteM, ValidM. There is no stall on M or W.
- W stage <= M unconditionally: RdW, RegWriteW, ValidW.
- Latency: a D-stage tag reaches E at +1 cycle, M at +2, W at +3, absent flush.
- Load-use case (StallD=1, FlushE=1): D holds, E gets a bubble, and the same D tags re-enter E in the next unstalled cycle.
- StallCnt increments when StallD & ~FlushD.
- BubbleCnt increments when FlushE.
- RetireCnt increments when ValidW.
- Counters saturate at 2^CNTW-1 and do not wrap.
- ClrCnt zeroes all three counters and takes priority over increment in the same cycle.
- Counters update on the same edge as the pipeline registers.
- All outputs come directly from registers; no combinational input-to-output path.

Test Plan:
- Reset: hold reset=0 for 2 cycles with ValidF=1 -> all outputs 0; after release, ValidD=1 on the 1st edge.
- Straight flow: D tags Rd=5, RegWrite=1, no stall/flush -> RdE=5 at +1, RdM=5/RegWriteM=1 at +2, RdW=5/RegWriteW=1/ValidW=1 at +3; RetireCnt=1 after the next edge.
- Load-use: D ResultSrcD=1, Rd=3, with StallD=FlushE=1 for one cycle ->
  - E is a bubble (RdE=0, ResultSrcE=0); StallCnt=1, BubbleCnt=1.
  - Same D tags appear in E the following cycle.
- Simultaneous FlushD+StallD -> ValidD=0 next cycle; StallCnt unchanged.
- Bubble propagation: FlushE for one cycle -> RegWriteM=0 at +2, RegWriteW=0 and ValidW=0 at +3; RetireCnt not incremented for that slot.
- Saturation/clear, with CNTW=2:
  - 5 consecutive FlushE cycles -> BubbleCnt stays at 3.
  - ClrCnt asserted together with FlushE -> BubbleCnt=0.
